// File: rtl/holdreg_queue.sv
// holdreg_queue: per-port request assembly and queueing.
// Each port has a two-state capture FSM and a DEPTH-entry FIFO. A request is
// cmd+op1 in one cycle and op2 in the next. Assembled entries are pushed into
// the FIFO. The head entry is offered to the priority logic through a
// valid/pop handshake.
module holdreg_queue #(
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 4,
  parameter int CMD_W     = 4,
  parameter int DATA_W    = 32,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                        c_clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*CMD_W-1:0]  req_cmd_in,
  input  logic [NUM_PORTS*DATA_W-1:0] req_data_in,
  input  logic [NUM_PORTS-1:0]        hold_pop,
  output logic [NUM_PORTS-1:0]        hold_valid,
  output logic [NUM_PORTS*CMD_W-1:0]  hold_cmd,
  output logic [NUM_PORTS*DATA_W-1:0] hold_data1,
  output logic [NUM_PORTS*DATA_W-1:0] hold_data2,
  output logic [NUM_PORTS*CW-1:0]     hold_count,
  output logic [NUM_PORTS-1:0]        overflow,
  output logic [NUM_PORTS-1:0]        protocol_err
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, OP2 = 1'b1} state_t;

  // Pointer advance with explicit wrap, so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    state_t            state_q, state_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              perr_q, perr_d;
    logic              push, pop_eff, push_ok;
    logic [CMD_W-1:0]  cmd_in;
    logic [DATA_W-1:0] data_in;

    logic [CMD_W-1:0]  mem_cmd [DEPTH];
    logic [DATA_W-1:0] mem_d1  [DEPTH];
    logic [DATA_W-1:0] mem_d2  [DEPTH];

    assign cmd_in  = req_cmd_in[p*CMD_W +: CMD_W];
    assign data_in = req_data_in[p*DATA_W +: DATA_W];

    // Capture FSM next state plus FIFO pointer/count/flag update.
    always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      op1_d      = op1_q;
      perr_d     = perr_q;
      push       = 1'b0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      case (state_q)
        IDLE: begin
          if (cmd_in != '0) begin
            cmd_d   = cmd_in;
            op1_d   = data_in;
            state_d = OP2;
          end
        end
        OP2: begin
          // A nonzero cmd here is flagged, never treated as a new request.
          push    = 1'b1;
          state_d = IDLE;
          if (cmd_in != '0) perr_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase

      // A pop on the same edge frees the slot a full-queue push needs.
      pop_eff = hold_pop[p] && (count_q != '0);
      push_ok = push && ((count_q != CW'(DEPTH)) || pop_eff);

      if (push && !push_ok) overflow_d = 1'b1;
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_eff) rd_ptr_d = ptr_inc(rd_ptr_q);

      case ({push_ok, pop_eff})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // Control and request-assembly state; reset discards partial requests.
    always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
        state_q    <= IDLE;
        cmd_q      <= '0;
        op1_q      <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
        perr_q     <= 1'b0;
      end else begin
        state_q    <= state_d;
        cmd_q      <= cmd_d;
        op1_q      <= op1_d;
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        count_q    <= count_d;
        overflow_q <= overflow_d;
        perr_q     <= perr_d;
      end
    end

    // Queue storage: written on accepted pushes, deliberately not reset.
    always_ff @(posedge c_clk) begin
      if (push_ok) begin
        mem_cmd[wr_ptr_q] <= cmd_q;
        mem_d1[wr_ptr_q]  <= op1_q;
        mem_d2[wr_ptr_q]  <= data_in;
      end
    end

    // Head outputs read storage directly and are forced to 0 when empty.
    assign hold_valid[p]                  = (count_q != '0);
    assign hold_cmd[p*CMD_W +: CMD_W]     = hold_valid[p] ? mem_cmd[rd_ptr_q] : '0;
    assign hold_data1[p*DATA_W +: DATA_W] = hold_valid[p] ? mem_d1[rd_ptr_q]  : '0;
    assign hold_data2[p*DATA_W +: DATA_W] = hold_valid[p] ? mem_d2[rd_ptr_q]  : '0;
    assign hold_count[p*CW +: CW]         = count_q;
    assign overflow[p]                    = overflow_q;
    assign protocol_err[p]                = perr_q;
  end

endmodule
